switch_bounce_gen: RTL and testbench
====================================

# switch_bounce_gen

Synthesisable switch-bounce emulator: the inverse of the debouncer. It takes a clean, synchronous level and drives a bouncing copy of it on `sw_o`, paced by the same tick strobe the debouncer uses. It sits in front of `deboucing_circuito` in on-chip self-test and FPGA demo builds, so the debouncer can be exercised without a mechanical switch.

## Interface
- `INIT_LEVEL`, 1'b0: value of `sw_o` and the internal committed level after reset.
- `MAX_PAIRS`, 2: maximum number of extra glitch pairs per transition (0..255).
- `SETTLE_TICKS`, 3: ticks `sw_o` must stay stable after the last toggle before the transition counts as complete (1..255).
- `RANDOM`, 1'b0: 0 gives deterministic bouncing (P = MAX_PAIRS, G = 1); 1 gives LFSR-driven P and G.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk_i` input 1: system clock; all logic runs on its rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `level_i` input 1: clean target level. Synchronous to `clk_i`.
- `tick_i` input 1: single-cycle bounce timebase strobe, the same kind of strobe as the debouncer's `m_tick_i`.
- `sw_o` output 1: bouncing switch output, registered.
- `busy_o` output 1: high while in BOUNCE or SETTLE.
- `settled_o` output 1: one-cycle pulse when a transition completes.

## Operation
- State machine has three states: IDLE, BOUNCE, SETTLE. The committed level `tgt_q` holds the level of the last accepted transition.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right every clock, and loads `SEED` on reset. It runs in both values of `RANDOM`.
- IDLE, when `level_i != tgt_q`:
  - On the same edge: `tgt_q <= level_i`, `sw_o <= level_i` (first toggle), load the pair count P, load the gap G, clear the gap counter, and go to BOUNCE.
  - If P = 0, go directly to SETTLE instead.
- P and G values:
  - `RANDOM=1`: P = min(lfsr[1:0], MAX_PAIRS) and G = 1 + lfsr[3:2]. Both are sampled from the current LFSR value.
  - `RANDOM=0`: P = MAX_PAIRS and G = 1.
- BOUNCE:
  - Each `tick_i` increments the gap counter.
  - On the tick where the counter reaches G, `sw_o` inverts, the counter clears, and a new G is loaded.
  - A toggle that returns `sw_o` to `tgt_q` completes one pair and decrements P. When P reaches 0 on that toggle, go to SETTLE.
  - Total toggles per transition = 1 + 2P, so the final level always equals `tgt_q`.
- SETTLE:
  - Counts `tick_i` pulses. On the SETTLE_TICKS-th tick, go to IDLE and pulse `settled_o` on that edge.
  - Any toggle is illegal here; `sw_o` must equal `tgt_q` throughout.
- Changes of `level_i` during BOUNCE or SETTLE are ignored, not queued. If `level_i != tgt_q` in the first IDLE cycle, a new transition starts on that edge.
- `level_i` returning to `tgt_q` while IDLE does nothing.

## Timing
- Reset values: `sw_o` = INIT_LEVEL, `tgt_q` = INIT_LEVEL, `busy_o` = 0, `settled_o` = 0, state IDLE, counters 0, LFSR = SEED.
- Reset mid-BOUNCE or mid-SETTLE aborts immediately and returns everything to the reset values; no `settled_o` is emitted.
- Latency from `level_i` to `sw_o` is 1 clock: sampled at edge k, visible after edge k.
- `busy_o` is registered and rises on the same edge as the first toggle. It falls on the edge that pulses `settled_o`, so `busy_o` = 0 and `settled_o` = 1 occur in the same cycle.
- If `tick_i` is asserted in the same cycle as the IDLE-to-BOUNCE transition, it is not counted.
- If `tick_i` is held high for consecutive cycles, each cycle counts as a tick.
- Minimum BOUNCE+SETTLE duration is (2P·G + SETTLE_TICKS) ticks.
- If `tick_i` never arrives, the block stays in BOUNCE or SETTLE indefinitely; this is legal.

## Test plan
- **Reset.** `INIT_LEVEL=1`; assert `rst_i` for 2 cycles -> `sw_o`=1, `busy_o`=0, `settled_o`=0 while in reset and after release.
- **Deterministic rise.** `RANDOM=0`, `MAX_PAIRS=2`, `SETTLE_TICKS=3`, `level_i` 0->1:
  - `sw_o`=1 and `busy_o`=1 after 1 clock.
  - `sw_o` after ticks 1-4 = 0, 1, 0, 1.
  - `settled_o` pulses on the 7th tick with `busy_o`=0 in the same cycle; 5 toggles total.
- **Zero pairs.** `MAX_PAIRS=0`, `level_i` 1->0 -> single toggle to 0, then `settled_o` pulses after 3 ticks, with no glitches.
- **Ignored input changes.** Toggle `level_i` 1->0->1 during BOUNCE of a 0->1 transition -> no effect. After `settled_o`, `level_i`=1 = `tgt_q`, so the block stays IDLE. Then drive `level_i`=0 -> a new transition starts 1 clock later.
- **Reset mid-bounce.** Assert `rst_i` after tick 2 of the deterministic rise -> `sw_o`=INIT_LEVEL (0) immediately, `busy_o`=0, and no `settled_o` afterwards.
- **Random mode.** `RANDOM=1`, `SEED=16'hACE1`, 20 transitions with the debouncer attached:
  - Each transition has an odd toggle count ≤ 1+2·MAX_PAIRS, and `sw_o` equals `level_i` at every `settled_o`.
  - Gaps between toggles are in 1..4 ticks.
  - Debouncer output follows `level_i` once each transition has settled.

Source files
------------

// File: rtl/switch_bounce_gen.sv
// -----------------------------------------------------------------------------
// switch_bounce_gen
// Emulates a mechanical switch: follows a clean synchronous level but drives a
// bouncing copy on sw_o, paced by a tick strobe, so a debouncer can be
// exercised without real hardware.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   level_i    clean target level (synchronous to clk_i)
//   tick_i     single-cycle bounce timebase strobe
//   sw_o       bouncing switch output (registered)
//   busy_o     high while a transition is bouncing or settling
//   settled_o  one-cycle pulse when a transition completes
//
// State table
//   ST_IDLE   | waiting for level_i to differ from the committed level
//   ST_BOUNCE | emitting glitch pairs, one toggle every G ticks
//   ST_SETTLE | sw_o held at the committed level for SETTLE_TICKS ticks
// -----------------------------------------------------------------------------
module switch_bounce_gen #(
    parameter logic        INIT_LEVEL   = 1'b0,
    parameter int          MAX_PAIRS    = 2,
    parameter int          SETTLE_TICKS = 3,
    parameter logic        RANDOM       = 1'b0,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    input  logic tick_i,
    output logic sw_o,
    output logic busy_o,
    output logic settled_o
);

    localparam logic [7:0] LP_MAX_PAIRS = 8'(MAX_PAIRS);
    localparam logic [7:0] LP_SETTLE    = 8'(SETTLE_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic        r_tgt,        w_tgt_nxt;
    logic        r_sw,         w_sw_nxt;
    logic        r_busy,       w_busy_nxt;
    logic        r_settled,    w_settled_nxt;
    logic [7:0]  r_pairs,      w_pairs_nxt;
    logic [2:0]  r_gap_rem,    w_gap_rem_nxt;
    logic [7:0]  r_settle_cnt, w_settle_cnt_nxt;
    logic [15:0] r_lfsr,       w_lfsr_nxt;

    logic [7:0]  w_p_load;
    logic [2:0]  w_g_load;

    // Galois LFSR, shifting right, free-running regardless of RANDOM
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    generate
        if (RANDOM) begin : g_random
            assign w_p_load = ({6'd0, r_lfsr[1:0]} < LP_MAX_PAIRS) ? {6'd0, r_lfsr[1:0]}
                                                                   : LP_MAX_PAIRS;
            assign w_g_load = 3'd1 + {1'b0, r_lfsr[3:2]};
        end else begin : g_fixed
            assign w_p_load = LP_MAX_PAIRS;
            assign w_g_load = 3'd1;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_tgt        <= INIT_LEVEL;
            r_sw         <= INIT_LEVEL;
            r_busy       <= 1'b0;
            r_settled    <= 1'b0;
            r_pairs      <= 8'd0;
            r_gap_rem    <= 3'd0;
            r_settle_cnt <= 8'd0;
            r_lfsr       <= SEED;
        end else begin
            r_state      <= w_state_nxt;
            r_tgt        <= w_tgt_nxt;
            r_sw         <= w_sw_nxt;
            r_busy       <= w_busy_nxt;
            r_settled    <= w_settled_nxt;
            r_pairs      <= w_pairs_nxt;
            r_gap_rem    <= w_gap_rem_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_lfsr       <= w_lfsr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tgt_nxt        = r_tgt;
        w_sw_nxt         = r_sw;
        w_busy_nxt       = r_busy;
        w_settled_nxt    = 1'b0;
        w_pairs_nxt      = r_pairs;
        w_gap_rem_nxt    = r_gap_rem;
        w_settle_cnt_nxt = r_settle_cnt;

        case (r_state)
            ST_IDLE: begin
                // A tick coinciding with this edge is deliberately not counted
                if (level_i != r_tgt) begin
                    w_tgt_nxt     = level_i;
                    w_sw_nxt      = level_i;
                    w_busy_nxt    = 1'b1;
                    w_pairs_nxt   = w_p_load;
                    w_gap_rem_nxt = w_g_load;
                    if (w_p_load == 8'd0) begin
                        w_state_nxt      = ST_SETTLE;
                        w_settle_cnt_nxt = LP_SETTLE;
                    end else begin
                        w_state_nxt = ST_BOUNCE;
                    end
                end
            end

            ST_BOUNCE: begin
                // Gap timer counts down the ticks remaining until the next toggle
                if (tick_i) begin
                    if (r_gap_rem == 3'd1) begin
                        w_sw_nxt      = ~r_sw;
                        w_gap_rem_nxt = w_g_load;
                        // Toggling back onto the target closes one glitch pair
                        if (r_sw != r_tgt) begin
                            w_pairs_nxt = r_pairs - 8'd1;
                            if (r_pairs == 8'd1) begin
                                w_state_nxt      = ST_SETTLE;
                                w_settle_cnt_nxt = LP_SETTLE;
                            end
                        end
                    end else begin
                        w_gap_rem_nxt = r_gap_rem - 3'd1;
                    end
                end
            end

            ST_SETTLE: begin
                if (tick_i) begin
                    if (r_settle_cnt == 8'd1) begin
                        w_state_nxt   = ST_IDLE;
                        w_busy_nxt    = 1'b0;
                        w_settled_nxt = 1'b1;
                    end else begin
                        w_settle_cnt_nxt = r_settle_cnt - 8'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sw_o      = r_sw;
    assign busy_o    = r_busy;
    assign settled_o = r_settled;

endmodule

// File: tb/tb_switch_bounce_gen.sv
module tb_switch_bounce_gen;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic lvl_det, lvl_zp, lvl_rnd;
    logic sw_det, busy_det, set_det;
    logic sw_zp,  busy_zp,  set_zp;
    logic sw_rnd, busy_rnd, set_rnd;

    always #5 clk = ~clk;

    // Deterministic, two pairs
    switch_bounce_gen #(.INIT_LEVEL(1'b0), .MAX_PAIRS(2), .SETTLE_TICKS(3),
                        .RANDOM(1'b0), .SEED(16'hACE1)) u_det (
        .clk_i(clk), .rst_i(rst), .level_i(lvl_det), .tick_i(tick),
        .sw_o(sw_det), .busy_o(busy_det), .settled_o(set_det));

    // Zero pairs, resets high
    switch_bounce_gen #(.INIT_LEVEL(1'b1), .MAX_PAIRS(0), .SETTLE_TICKS(3),
                        .RANDOM(1'b0), .SEED(16'hACE1)) u_zp (
        .clk_i(clk), .rst_i(rst), .level_i(lvl_zp), .tick_i(tick),
        .sw_o(sw_zp), .busy_o(busy_zp), .settled_o(set_zp));

    // LFSR-driven bouncing
    switch_bounce_gen #(.INIT_LEVEL(1'b0), .MAX_PAIRS(2), .SETTLE_TICKS(3),
                        .RANDOM(1'b1), .SEED(16'hACE1)) u_rnd (
        .clk_i(clk), .rst_i(rst), .level_i(lvl_rnd), .tick_i(tick),
        .sw_o(sw_rnd), .busy_o(busy_rnd), .settled_o(set_rnd));

    // Simple debouncer model: adopts sw after two consecutive differing ticks
    logic deb;
    int   dcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            deb  <= 1'b0;
            dcnt <= 0;
        end else if (tick) begin
            if (sw_rnd == deb) dcnt <= 0;
            else if (dcnt == 1) begin
                deb  <= sw_rnd;
                dcnt <= 0;
            end else dcnt <= dcnt + 1;
        end
    end

    typedef struct {
        int   sel;
        logic lvl;
        logic tck;
        logic sw;
        logic busy;
        logic set;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vidx     = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input int sel, input logic l, input logic t,
                       input logic s, input logic b, input logic st);
        vec_t v;
        v.sel = sel; v.lvl = l; v.tck = t; v.sw = s; v.busy = b; v.set = st;
        vecs.push_back(v);
    endtask

    task automatic compare_front();
        vec_t e;
        logic s, b, st;
        e = sb_q.pop_front();
        case (e.sel)
            0:       begin s = sw_det; b = busy_det; st = set_det; end
            default: begin s = sw_zp;  b = busy_zp;  st = set_zp;  end
        endcase
        chk($sformatf("vec%0d sw", vidx),      int'(s),  int'(e.sw));
        chk($sformatf("vec%0d busy", vidx),    int'(b),  int'(e.busy));
        chk($sformatf("vec%0d settled", vidx), int'(st), int'(e.set));
        vidx++;
    endtask

    task automatic apply(input vec_t v);
        if (v.sel == 0) lvl_det = v.lvl;
        else            lvl_zp  = v.lvl;
        tick = v.tck;
        sb_q.push_back(v);
        @(negedge clk);
        compare_front();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   toggles, gap;
        logic prev, cyc_tick, done;

        // sel | lvl tick | sw busy settled  (outputs after the edge)
        // deterministic rise; start-edge tick ignored; level glitches ignored
        add(0, 1, 1, 1, 1, 0);
        add(0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 1, 1, 0);
        add(0, 0, 1, 0, 1, 0);
        add(0, 1, 1, 1, 1, 0);
        add(0, 1, 1, 1, 1, 0);
        add(0, 1, 1, 1, 1, 0);
        add(0, 1, 1, 1, 0, 1);
        add(0, 1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        // fall starts one clock after level_i drops
        add(0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 1, 0);
        add(0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1);
        // zero pairs: single toggle then settle
        add(1, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 1, 0);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0);

        rst = 1'b1; tick = 1'b0;
        lvl_det = 1'b0; lvl_zp = 1'b1; lvl_rnd = 1'b0;
        #1;
        chk("rst zp sw",       int'(sw_zp),   1);
        chk("rst zp busy",     int'(busy_zp), 0);
        chk("rst zp settled",  int'(set_zp),  0);
        chk("rst det sw",      int'(sw_det),  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst zp sw",      int'(sw_zp),   1);
        chk("post-rst zp busy",    int'(busy_zp), 0);
        chk("post-rst zp settled", int'(set_zp),  0);

        foreach (vecs[i]) apply(vecs[i]);

        // reset in the middle of a deterministic rise
        lvl_det = 1'b1; tick = 1'b0;
        @(negedge clk);
        chk("mid start sw",   int'(sw_det),   1);
        chk("mid start busy", int'(busy_det), 1);
        tick = 1'b1;
        @(negedge clk);
        chk("mid tick1 sw", int'(sw_det), 0);
        @(negedge clk);
        chk("mid tick2 sw", int'(sw_det), 1);
        tick = 1'b0; lvl_det = 1'b0; rst = 1'b1;
        #1;
        chk("mid rst sw",      int'(sw_det),   0);
        chk("mid rst busy",    int'(busy_det), 0);
        chk("mid rst settled", int'(set_det),  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; tick = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("after rst settled", int'(set_det),  0);
            chk("after rst busy",    int'(busy_det), 0);
            chk("after rst sw",      int'(sw_det),   0);
        end
        tick = 1'b0;

        // random mode transitions
        for (int t = 0; t < 20; t++) begin
            lvl_rnd = ~lvl_rnd;
            tick    = 1'b0;
            toggles = 0; gap = 0; done = 1'b0;
            prev    = sw_rnd;
            for (int c = 0; c < 500 && !done; c++) begin
                cyc_tick = tick;
                @(negedge clk);
                if (sw_rnd !== prev) begin
                    if (toggles > 0) begin
                        gap += int'(cyc_tick);
                        chk($sformatf("rnd%0d gap", t), int'(gap >= 1 && gap <= 4), 1);
                    end
                    toggles++;
                    gap  = 0;
                    prev = sw_rnd;
                end else if (toggles > 0) begin
                    gap += int'(cyc_tick);
                end
                if (set_rnd) done = 1'b1;
                tick = 1'($urandom_range(0, 1));
            end
            chk($sformatf("rnd%0d settled seen", t), int'(done), 1);
            chk($sformatf("rnd%0d toggles odd", t), toggles % 2, 1);
            chk($sformatf("rnd%0d toggles max", t), int'(toggles <= 5), 1);
            chk($sformatf("rnd%0d sw level", t), int'(sw_rnd), int'(lvl_rnd));
            chk($sformatf("rnd%0d busy low", t), int'(busy_rnd), 0);
            tick = 1'b1;
            repeat (6) @(negedge clk);
            chk($sformatf("rnd%0d debounced", t), int'(deb), int'(lvl_rnd));
            tick = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
